fetch_if_stage: RTL and testbench

- Instruction-fetch front end. Owns the PC and issues word reads to instruction memory.
- Buffers returned words in a small FIFO and presents {IR, PC, PC+4} to decode over a valid/ready handshake.
- Its id_ir output is the IR that decode and the immediate generator consume.
- Accepts redirects (branch/jump resolution, exceptions) from later stages and discards wrong-path fetches.

---
 rtl/fetch_if_stage.sv | 196 +++++++++++++++++++
 tb/tb_fetch_if_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_if_stage.sv
// fetch_if_stage: instruction-fetch front end.
//
// Owns the fetch PC, issues single-word reads to instruction memory (one
// request in flight at a time for the live path) and buffers the returned
// words in a small FIFO.  The FIFO head is presented to decode as
// {id_ir, id_pc, id_pc4, id_pred_taken} over a valid/ready handshake.
// Redirects from later stages flush the FIFO and restart fetch; responses
// to requests issued before a redirect are dropped on return.
//
// Optional feature (macro FETCH_STATIC_PREDICT_EN): static prediction on
// push -- JAL and backward conditional branches steer the PC to their
// target and mark the entry id_pred_taken=1.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   imem_req/imem_addr/imem_gnt  fetch request channel (addr held until gnt)
//   imem_rvalid/imem_rdata       in-order read response channel
//   redirect_valid/redirect_pc   flush and restart fetch at redirect_pc
//   id_valid/id_ready            decode handshake on the FIFO head
//   id_ir/id_pc/id_pc4/id_pred_taken  head entry (NOP/0/0/0 when empty)
module fetch_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_pred_taken
);

  localparam int          PW      = $clog2(BUF_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(BUF_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state_reg;
  logic [31:0]   pc_reg;
  logic [31:0]   req_pc_reg;
  logic          imem_req_reg;
  // Number of stale responses still to come back.  A redirect can land while
  // a stale response is pending and the restarted request is already out, so
  // up to two may be owed; requests are held off while two are pending.
  logic [1:0]    discard_reg;
  logic [1:0]    discard_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW:0]   count_reg;

  logic [31:0]   buf_ir   [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic          buf_pred [BUF_DEPTH];

  logic          stale_rsp;
  logic          live_rsp;
  logic          live_after;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic          pred_w;
  logic [31:0]   pred_target;
  logic          unused_bits;

  // Responses are in order, so while any stale response is owed the next
  // rvalid belongs to it.
  assign stale_rsp  = imem_rvalid && (discard_reg != 2'd0);
  assign live_rsp   = imem_rvalid && (discard_reg == 2'd0) && (state_reg == S_WAIT);
  // A live request still in flight after this cycle becomes stale on redirect.
  assign live_after = ((state_reg == S_REQ) && imem_gnt) ||
                      ((state_reg == S_WAIT) && !live_rsp);
  assign push       = live_rsp && !redirect_valid;
  assign pop        = (count_reg != '0) && id_ready && !redirect_valid;
  assign can_issue  = (count_reg < DEPTH_C) && (discard_reg != 2'd2);

  assign discard_next = discard_reg - {1'b0, stale_rsp}
                      + {1'b0, redirect_valid && live_after};

  assign unused_bits = ^redirect_pc[1:0];

`ifdef FETCH_STATIC_PREDICT_EN
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  always_comb begin
    j_imm       = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                   imem_rdata[30:21], 1'b0};
    b_imm       = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                   imem_rdata[11:8], 1'b0};
    pred_w      = 1'b0;
    pred_target = pc_reg;
    if (imem_rdata[6:0] == 7'b1101111) begin
      pred_w      = 1'b1;
      pred_target = req_pc_reg + j_imm;
    end else if ((imem_rdata[6:0] == 7'b1100011) && imem_rdata[31]) begin
      pred_w      = 1'b1;
      pred_target = req_pc_reg + b_imm;
    end
  end
`else
  assign pred_w      = 1'b0;
  assign pred_target = pc_reg;
`endif

  // Request FSM, fetch PC and discard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      pc_reg       <= RESET_PC;
      req_pc_reg   <= 32'h0;
      imem_req_reg <= 1'b0;
      discard_reg  <= 2'd0;
    end else begin
      discard_reg <= discard_next;
      if (redirect_valid) begin
        state_reg    <= S_IDLE;
        imem_req_reg <= 1'b0;
        pc_reg       <= {redirect_pc[31:2], 2'b00};
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (can_issue) begin
              state_reg    <= S_REQ;
              imem_req_reg <= 1'b1;
            end
          end
          S_REQ: begin
            if (imem_gnt) begin
              pc_reg       <= pc_reg + 32'd4;
              req_pc_reg   <= pc_reg;
              state_reg    <= S_WAIT;
              imem_req_reg <= 1'b0;
            end
          end
          S_WAIT: begin
            if (live_rsp) begin
              state_reg <= S_IDLE;
              // Nothing is in flight here, so a predicted target needs no discard.
              if (pred_w) pc_reg <= pred_target;
            end
          end
          default: begin
            state_reg    <= S_IDLE;
            imem_req_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_ir[wr_ptr_reg]   <= imem_rdata;
      buf_pc[wr_ptr_reg]   <= req_pc_reg;
      buf_pred[wr_ptr_reg] <= pred_w;
    end
  end

  assign imem_req      = imem_req_reg;
  assign imem_addr     = pc_reg;
  assign id_valid      = (count_reg != '0);
  assign id_ir         = id_valid ? buf_ir[rd_ptr_reg] : NOP;
  assign id_pc         = id_valid ? buf_pc[rd_ptr_reg] : 32'h0;
  assign id_pc4        = id_valid ? (buf_pc[rd_ptr_reg] + 32'd4) : 32'h0;
  assign id_pred_taken = id_valid ? buf_pred[rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_fetch_if_stage.sv
// Testbench for fetch_if_stage: directed scenarios against an in-order
// memory model with programmable latency, plus a per-cycle check of the
// decode-side stream against a model of the expected instruction order.
module tb_fetch_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_STATIC_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_pred_taken;

  always #5 clk = ~clk;

  fetch_if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_pred_taken(id_pred_taken)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] w40 = 32'h0000_0813;   // word at 0x40, replaceable by the tests
  logic        gnt_en = 1'b1;
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] g_q[$];                // granted addresses (live grants only)
  int          issued_since = 0;      // live grants since reset/last redirect

  // Default content is an OP-IMM word that encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return w40;
    return {a[26:2], 7'b0010011};
  endfunction

  assign imem_gnt = imem_req && gnt_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_addr.delete();
      mq_due.delete();
      issued_since = 0;
      cyc = 0;
      imem_rvalid <= 1'b0;
    end else begin
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
        if (!redirect_valid) begin
          g_q.push_back(imem_addr);
          issued_since++;
        end
      end
      if (redirect_valid) issued_since = 0;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc + 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'hDEAD_BEEF;
      end
      cyc++;
    end
  end

  // ---------------- stream model and per-cycle compare ----------------
  logic [31:0] model_pc = RST_PC;
  int          accepted_since = 0;
  logic [31:0] acc_pc_q[$];
  logic [31:0] acc_pc4_q[$];
  logic        acc_pred_q[$];
  logic        prev_valid = 0, prev_ready = 0, prev_redirect = 0;
  logic        prev_req = 0, prev_gnt = 0;
  logic [31:0] prev_pc = 0, prev_ir = 0, prev_addr = 0;

  function automatic logic exp_pred(input logic [31:0] w);
    return PRED_EN && ((w[6:0] == 7'b1101111) || (w[6:0] == 7'b1100011 && w[31]));
  endfunction

  // Address of the instruction that must follow the one at pc holding w.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
    logic [31:0] jimm;
    logic [31:0] bimm;
    jimm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    bimm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    if (PRED_EN && w[6:0] == 7'b1101111) return pc + jimm;
    if (PRED_EN && w[6:0] == 7'b1100011 && w[31]) return pc + bimm;
    return pc + 32'd4;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      model_pc = RST_PC;
      accepted_since = 0;
      prev_valid = 0; prev_redirect = 0; prev_req = 0; prev_gnt = 0;
    end else begin
      if (!id_valid) begin
        chk("idle_ir", id_ir, NOP);
        chk("idle_pc", id_pc, 32'h0);
        chk("idle_pc4", id_pc4, 32'h0);
        chk("idle_pred", {31'b0, id_pred_taken}, 32'h0);
      end else begin
        chk("head_pc", id_pc, model_pc);
        chk("head_ir", id_ir, mem_word(model_pc));
        chk("head_pc4", id_pc4, model_pc + 32'd4);
        chk("head_pred", {31'b0, id_pred_taken}, {31'b0, exp_pred(mem_word(model_pc))});
      end
      if (prev_redirect) chk("flush_empty", {31'b0, id_valid}, 32'h0);
      if (prev_valid && !prev_ready && !prev_redirect) begin
        chk("hold_valid", {31'b0, id_valid}, 32'h1);
        chk("hold_pc", id_pc, prev_pc);
        chk("hold_ir", id_ir, prev_ir);
      end
      if (prev_req && !prev_gnt && !prev_redirect) begin
        chk("req_hold", {31'b0, imem_req}, 32'h1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (id_valid && id_ready) begin
        acc_pc_q.push_back(id_pc);
        acc_pc4_q.push_back(id_pc4);
        acc_pred_q.push_back(id_pred_taken);
        if (!redirect_valid) accepted_since++;
        model_pc = next_pc(model_pc, mem_word(model_pc));
      end
      if (redirect_valid) begin
        model_pc = {redirect_pc[31:2], 2'b00};
        accepted_since = 0;
      end
      prev_valid = id_valid; prev_ready = id_ready; prev_redirect = redirect_valid;
      prev_req = imem_req; prev_gnt = imem_gnt;
      prev_pc = id_pc; prev_ir = id_ir; prev_addr = imem_addr;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step(1);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic clear_logs();
    g_q.delete();
    acc_pc_q.delete();
    acc_pc4_q.delete();
    acc_pred_q.delete();
  endtask

  task automatic wait_accepted(input string name, input int n);
    for (int i = 0; i < 200 && accepted_since < n; i++) step(1);
    chk(name, {31'b0, accepted_since >= n}, 32'h1);
  endtask

  function automatic logic [31:0] g_at(input int i);
    if (i < g_q.size()) return g_q[i];
    return 32'hBAD0_BAD0;
  endfunction

  function automatic logic [31:0] a_at(input int i);
    if (i < acc_pc_q.size()) return acc_pc_q[i];
    return 32'hBAD0_BAD0;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int snap;
    // Reset state
    step(2);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_ir", id_ir, NOP);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    chk("rst_pred", {31'b0, id_pred_taken}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    wait_accepted("a_timeout", 3);
    chk("a_gnt0", g_at(0), 32'h100);
    chk("a_gnt1", g_at(1), 32'h104);
    chk("a_gnt2", g_at(2), 32'h108);
    chk("a_acc0", a_at(0), 32'h100);
    chk("a_acc1", a_at(1), 32'h104);
    chk("a_acc2", a_at(2), 32'h108);
    chk("a_pc4_0", acc_pc4_q.size() > 0 ? acc_pc4_q[0] : 32'hBAD0_BAD0, 32'h104);

    // Back-pressure: buffer fills to DEPTH, then fetch stops
    id_ready = 1'b0;
    step(6);
    snap = issued_since;
    step(4);
    chk("b_no_new_gnt", issued_since, snap);
    chk("b_buffered", issued_since - accepted_since, DEPTH);
    chk("b_req_low", {31'b0, imem_req}, 32'h0);
    chk("b_mem_idle", mq_addr.size(), 32'h0);
    id_ready = 1'b1;
    step(12);

    // Grant held off: request and address must stay put
    gnt_en = 1'b0;
    step(4);
    chk("g_req_held", {31'b0, imem_req}, 32'h1);
    gnt_en = 1'b1;
    step(4);

    // Redirect while the fetch of 0x10C waits for its response
    lat = 3;
    do_redirect(32'h10C);
    clear_logs();
    for (int i = 0; i < 100 && !(g_q.size() > 0 && g_q[g_q.size()-1] == 32'h10C); i++) step(1);
    chk("c_saw_10c", g_at(0), 32'h10C);
    do_redirect(32'h203);   // low bits must be ignored
    clear_logs();
    chk("c_withdrawn", {31'b0, imem_req}, 32'h0);
    step(1);
    chk("c_restart_req", {31'b0, imem_req}, 32'h1);
    chk("c_restart_addr", imem_addr, 32'h200);
    wait_accepted("c_timeout", 2);
    chk("c_acc0", a_at(0), 32'h200);
    chk("c_acc1", a_at(1), 32'h204);

    // Redirect in the same cycle as a grant
    lat = 2;
    for (int i = 0; i < 100 && !imem_req; i++) step(1);
    chk("d1_req_seen", {31'b0, imem_req}, 32'h1);
    do_redirect(32'h300);
    clear_logs();
    wait_accepted("d1_timeout", 1);
    chk("d1_acc0", a_at(0), 32'h300);

    // Redirect in the same cycle as a response
    for (int i = 0; i < 100 && !imem_rvalid; i++) step(1);
    chk("d2_rvalid_seen", {31'b0, imem_rvalid}, 32'h1);
    do_redirect(32'h400);
    clear_logs();
    wait_accepted("d2_timeout", 1);
    chk("d2_acc0", a_at(0), 32'h400);

    // Back-to-back redirects: the last one wins
    lat = 4;
    clear_logs();
    for (int i = 0; i < 100 && g_q.size() == 0; i++) step(1);
    do_redirect(32'h500);
    do_redirect(32'h600);
    clear_logs();
    wait_accepted("d3_timeout", 2);
    chk("d3_acc0", a_at(0), 32'h600);
    chk("d3_acc1", a_at(1), 32'h604);

    // PC wrap at the top of the address space
    lat = 1;
    do_redirect(32'hFFFF_FFF8);
    clear_logs();
    wait_accepted("e_timeout", 3);
    chk("e_gnt0", g_at(0), 32'hFFFF_FFF8);
    chk("e_gnt1", g_at(1), 32'hFFFF_FFFC);
    chk("e_gnt2", g_at(2), 32'h0000_0000);
    chk("e_acc1", a_at(1), 32'hFFFF_FFFC);
    chk("e_pc4_wrap", acc_pc4_q.size() > 1 ? acc_pc4_q[1] : 32'hBAD0_BAD0, 32'h0);

    // Backward branch at 0x40 (beq x0,x0,-4)
    w40 = 32'hFE00_0EE3;
    do_redirect(32'h40);
    clear_logs();
    wait_accepted("f1_timeout", 2);
    chk("f1_gnt0", g_at(0), 32'h40);
    chk("f1_gnt1", g_at(1), PRED_EN ? 32'h3C : 32'h44);
    chk("f1_pred", {31'b0, acc_pred_q.size() > 0 ? acc_pred_q[0] : 1'bx}, {31'b0, PRED_EN});
    chk("f1_acc1", a_at(1), PRED_EN ? 32'h3C : 32'h44);

    // Forward branch at 0x40: never predicted
    do_redirect(32'h80);
    step(3);
    w40 = 32'h0000_0463;
    do_redirect(32'h40);
    clear_logs();
    wait_accepted("f2_timeout", 2);
    chk("f2_gnt1", g_at(1), 32'h44);
    chk("f2_pred", {31'b0, acc_pred_q.size() > 0 ? acc_pred_q[0] : 1'bx}, 32'h0);
    chk("f2_acc1", a_at(1), 32'h44);

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
